alu_seq_unit: RTL and testbench

Parametrised, handshaked successor to the single-cycle ALU datapath. It holds registered A/B operands and executes one operation per `start` request. Single-cycle ops complete in 2 cycles; an iterative shift-add unsigned multiply takes `ALU_WIDTH` steps. It returns a registered result, a high-half product, a full NZCV flag set and compare flags. It sits between the register-file buses and the control sequencer, which uses `busy`/`done` instead of fixed EXECUTE1/EXECUTE2 slots.

---
 rtl/alu_seq_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// Handshaked sequential ALU: registered operands, one op per start, iterative shift-add multiply.
// Single-cycle ops finish in 2 cycles, mul in ALU_WIDTH+1; loads/start are ignored while busy.
module alu_seq_unit #(
  parameter int ALU_WIDTH = 8,
  parameter int ALU_OPS   = 16
) (
  input  logic                       sysclk,
  input  logic                       rst_n,
  input  logic [ALU_WIDTH-1:0]       A_bus,
  input  logic [ALU_WIDTH-1:0]       B_bus,
  input  logic                       a_load,
  input  logic                       b_load,
  input  logic                       start,
  input  logic [$clog2(ALU_OPS)-1:0] alu_op,
  output logic                       busy,
  output logic                       done,
  output logic                       op_err,
  output logic [ALU_WIDTH-1:0]       alu_result,
  output logic [ALU_WIDTH-1:0]       alu_result_hi,
  output logic                       flag_n,
  output logic                       flag_z,
  output logic                       flag_c,
  output logic                       flag_v,
  output logic                       cc_greater,
  output logic                       cc_equal
);
  localparam int W   = ALU_WIDTH;
  localparam int OPW = $clog2(ALU_OPS);
  localparam int SHW = $clog2(ALU_WIDTH);

  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(2);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3);
  localparam logic [OPW-1:0] OP_AND = OPW'(4);
  localparam logic [OPW-1:0] OP_NOT = OPW'(5);
  localparam logic [OPW-1:0] OP_LSL = OPW'(6);
  localparam logic [OPW-1:0] OP_LSR = OPW'(7);
  localparam logic [OPW-1:0] OP_ASR = OPW'(8);
  localparam logic [OPW-1:0] OP_CMP = OPW'(9);
  localparam logic [OPW-1:0] OP_MUL = OPW'(10);
  localparam logic [OPW-1:0] OP_ROL = OPW'(11);
  localparam logic [OPW-1:0] OP_ROR = OPW'(12);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_reg_q, a_reg_d, b_reg_q, b_reg_d;
  logic [OPW-1:0] op_w_q, op_w_d;
  logic [W-1:0]   a_w_q, a_w_d, b_w_q, b_w_d;
  logic [W-1:0]   mhi_q, mhi_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   res_q, res_d, hi_q, hi_d;
  logic           n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  logic           gt_q, gt_d, eq_q, eq_d, err_q, err_d;

  logic [W:0]        add_w, sub_w, lsl_w, lsr_w;
  logic signed [W:0] asr_w;
  logic [SHW-1:0]    rot_amt;
  logic [W-1:0]      rol_res, ror_res;
  logic [W:0]        mul_sum;
  logic [W-1:0]      mul_hi_nx, mul_lo_nx;

  logic [W-1:0] ex_res;
  logic         ex_c, ex_v, ex_cmp, ex_err;

  // Shift datapaths carry one extra bit to capture the last bit shifted out.
  assign add_w   = {1'b0, a_w_q} + {1'b0, b_w_q};
  assign sub_w   = {1'b0, a_w_q} - {1'b0, b_w_q};
  assign lsl_w   = {1'b0, a_w_q} << b_w_q;
  assign lsr_w   = {a_w_q, 1'b0} >> b_w_q;
  assign asr_w   = $signed({a_w_q, 1'b0}) >>> b_w_q;
  assign rot_amt = SHW'(b_w_q % ALU_WIDTH);
  assign rol_res = (a_w_q << rot_amt) | (a_w_q >> (ALU_WIDTH - int'(rot_amt)));
  assign ror_res = (a_w_q >> rot_amt) | (a_w_q << (ALU_WIDTH - int'(rot_amt)));

  // One shift-add step: b_w_q doubles as the multiplier and the low product half.
  assign mul_sum   = {1'b0, mhi_q} + (b_w_q[0] ? {1'b0, a_w_q} : {(W+1){1'b0}});
  assign mul_hi_nx = mul_sum[W:1];
  assign mul_lo_nx = {mul_sum[0], b_w_q[W-1:1]};

  always_comb begin
    ex_res = '0;
    ex_c   = 1'b0;
    ex_v   = 1'b0;
    ex_cmp = 1'b0;
    ex_err = 1'b0;
    case (op_w_q)
      OP_NOP, OP_MUL: ex_res = '0;
      OP_ADD: begin
        ex_res = add_w[W-1:0];
        ex_c   = add_w[W];
        ex_v   = (a_w_q[W-1] == b_w_q[W-1]) && (add_w[W-1] != a_w_q[W-1]);
      end
      OP_SUB, OP_CMP: begin
        ex_res = sub_w[W-1:0];
        ex_c   = ~sub_w[W];
        ex_v   = (a_w_q[W-1] != b_w_q[W-1]) && (sub_w[W-1] != a_w_q[W-1]);
        ex_cmp = (op_w_q == OP_CMP);
      end
      OP_OR:  ex_res = a_w_q | b_w_q;
      OP_AND: ex_res = a_w_q & b_w_q;
      OP_NOT: ex_res = ~a_w_q;
      OP_LSL: begin
        ex_res = lsl_w[W-1:0];
        ex_c   = lsl_w[W];
      end
      OP_LSR: begin
        ex_res = lsr_w[W:1];
        ex_c   = lsr_w[0];
      end
      OP_ASR: begin
        ex_res = asr_w[W:1];
        ex_c   = asr_w[0];
      end
      OP_ROL: begin
        ex_res = rol_res;
        ex_c   = (rot_amt != '0) && rol_res[0];
      end
      OP_ROR: begin
        ex_res = ror_res;
        ex_c   = (rot_amt != '0) && ror_res[W-1];
      end
      default: ex_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_reg_d = a_reg_q;
    b_reg_d = b_reg_q;
    op_w_d  = op_w_q;
    a_w_d   = a_w_q;
    b_w_d   = b_w_q;
    mhi_d   = mhi_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (a_load) a_reg_d = A_bus;
        if (b_load) b_reg_d = B_bus;
        if (start) begin
          op_w_d  = alu_op;
          a_w_d   = a_load ? A_bus : a_reg_q;
          b_w_d   = b_load ? B_bus : b_reg_q;
          mhi_d   = '0;
          cnt_d   = '0;
          state_d = (alu_op == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        err_d = ex_err;
        n_d   = ex_res[W-1];
        z_d   = (ex_res == '0) && !ex_err;
        c_d   = ex_c;
        v_d   = ex_v;
        gt_d  = ex_cmp && (a_w_q > b_w_q);
        eq_d  = ex_cmp && (a_w_q == b_w_q);
        if (!ex_cmp) begin
          res_d = ex_res;
          hi_d  = '0;
        end
        state_d = S_DONE;
      end
      S_MUL: begin
        mhi_d = mul_hi_nx;
        b_w_d = mul_lo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(ALU_WIDTH - 1)) begin
          res_d   = mul_lo_nx;
          hi_d    = mul_hi_nx;
          n_d     = mul_lo_nx[W-1];
          z_d     = (mul_lo_nx == '0);
          c_d     = (mul_hi_nx != '0);
          v_d     = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_reg_q <= '0;
      b_reg_q <= '0;
      op_w_q  <= '0;
      a_w_q   <= '0;
      b_w_q   <= '0;
      mhi_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_reg_q <= a_reg_d;
      b_reg_q <= b_reg_d;
      op_w_q  <= op_w_d;
      a_w_q   <= a_w_d;
      b_w_q   <= b_w_d;
      mhi_q   <= mhi_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      err_q   <= err_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign op_err        = done && err_q;
  assign alu_result    = res_q;
  assign alu_result_hi = hi_q;
  assign flag_n        = n_q;
  assign flag_z        = z_q;
  assign flag_c        = c_q;
  assign flag_v        = v_q;
  assign cc_greater    = gt_q;
  assign cc_equal      = eq_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomized bench for alu_seq_unit against an integer-arithmetic reference model.
module tb_alu_seq_unit;
  localparam int W = 8;

  logic         sysclk = 1'b0;
  logic         rst_n;
  logic [W-1:0] A_bus, B_bus;
  logic         a_load, b_load, start;
  logic [3:0]   alu_op;
  logic         busy, done, op_err;
  logic [W-1:0] alu_result, alu_result_hi;
  logic         flag_n, flag_z, flag_c, flag_v, cc_greater, cc_equal;

  always #5 sysclk = ~sysclk;

  alu_seq_unit #(.ALU_WIDTH(W), .ALU_OPS(16)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .A_bus(A_bus), .B_bus(B_bus),
    .a_load(a_load), .b_load(b_load), .start(start), .alu_op(alu_op),
    .busy(busy), .done(done), .op_err(op_err),
    .alu_result(alu_result), .alu_result_hi(alu_result_hi),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .cc_greater(cc_greater), .cc_equal(cc_equal)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_a, m_b, m_res, m_hi, m_n, m_z, m_c, m_v, m_gt, m_eq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  function automatic int sx(input int v);
    return (v >= (1 << (W-1))) ? v - (1 << W) : v;
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_res = 0; m_hi = 0;
    m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_gt = 0; m_eq = 0;
  endtask

  // Reference semantics of each opcode in plain integer arithmetic.
  task automatic model_exec(input int op, input int a, input int b);
    int mask = (1 << W) - 1;
    int r = 0, hi = 0, c = 0, v = 0, rr, sa, s;
    bit cmp = 0, err = 0;
    case (op)
      0: r = 0;
      1: begin
        r = (a + b) & mask; c = ((a + b) >> W) & 1;
        s = sx(a) + sx(b); v = (s > (mask >> 1)) || (s < -(1 << (W-1)));
      end
      2, 9: begin
        r = (a - b) & mask; c = (a >= b);
        s = sx(a) - sx(b); v = (s > (mask >> 1)) || (s < -(1 << (W-1)));
        cmp = (op == 9);
      end
      3: r = a | b;
      4: r = a & b;
      5: r = (~a) & mask;
      6: begin
        r = (b >= W) ? 0 : ((a << b) & mask);
        c = (b == 0 || b > W) ? 0 : ((a >> (W - b)) & 1);
      end
      7: begin
        r = (b >= W) ? 0 : (a >> b);
        c = (b == 0 || b > W) ? 0 : ((a >> (b - 1)) & 1);
      end
      8: begin
        sa = sx(a);
        r = (b >= W) ? ((sa < 0) ? mask : 0) : ((sa >>> b) & mask);
        c = (b == 0) ? 0 : (b > W) ? int'(sa < 0) : ((sa >>> (b - 1)) & 1);
      end
      10: begin
        r = (a * b) & mask; hi = (a * b) >> W; c = (hi != 0);
      end
      11: begin
        rr = b % W; r = ((a << rr) | (a >> (W - rr))) & mask;
        c = (rr != 0) && ((r & 1) != 0);
      end
      12: begin
        rr = b % W; r = ((a >> rr) | (a << (W - rr))) & mask;
        c = (rr != 0) && (((r >> (W-1)) & 1) != 0);
      end
      default: err = 1;
    endcase
    if (err) begin
      m_res = 0; m_hi = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_gt = 0; m_eq = 0;
    end else begin
      m_n = (r >> (W-1)) & 1; m_z = (r == 0); m_c = c; m_v = v;
      m_gt = cmp && (a > b); m_eq = cmp && (a == b);
      if (!cmp) begin m_res = r; m_hi = hi; end
    end
  endtask

  task automatic check_outputs(input string t);
    chk({t, ".res"}, alu_result, m_res);
    chk({t, ".hi"},  alu_result_hi, m_hi);
    chk({t, ".n"},   flag_n, m_n);
    chk({t, ".z"},   flag_z, m_z);
    chk({t, ".c"},   flag_c, m_c);
    chk({t, ".v"},   flag_v, m_v);
    chk({t, ".gt"},  cc_greater, m_gt);
    chk({t, ".eq"},  cc_equal, m_eq);
  endtask

  task automatic drive_noise();
    A_bus  = W'($urandom);
    B_bus  = W'($urandom);
    a_load = 1'($urandom);
    b_load = 1'($urandom);
    start  = 1'($urandom);
    alu_op = 4'($urandom);
  endtask

  task automatic clear_inputs();
    a_load = 0; b_load = 0; start = 0;
  endtask

  task automatic run_op(input string t, input int op, input bit la, input bit lb,
                        input int av, input int bv, input bit noise);
    int opa, opb, cnt, exp_lat;
    A_bus = W'(av); B_bus = W'(bv); a_load = la; b_load = lb;
    alu_op = 4'(op); start = 1;
    if (la) m_a = av & 8'hFF;
    if (lb) m_b = bv & 8'hFF;
    opa = m_a; opb = m_b;
    tick();
    clear_inputs();
    chk({t, ".busy_acc"}, busy, 1);
    chk({t, ".done_early"}, done, 0);
    exp_lat = (op == 10) ? W + 1 : 2;
    cnt = 1;
    while (done !== 1'b1 && cnt < exp_lat + 4) begin
      if (noise) drive_noise();
      tick();
      cnt++;
    end
    clear_inputs();
    chk({t, ".latency"}, cnt, exp_lat);
    chk({t, ".op_err"}, op_err, (op > 12) ? 1 : 0);
    model_exec(op, opa, opb);
    check_outputs(t);
    if (noise) drive_noise();
    tick();
    clear_inputs();
    chk({t, ".done_clr"}, done, 0);
    chk({t, ".busy_clr"}, busy, 0);
  endtask

  initial begin
    bit saw_done;
    int op, bv;
    A_bus = W'($urandom); B_bus = W'($urandom); alu_op = 4'($urandom);
    a_load = 1'($urandom); b_load = 1'($urandom); start = 1'($urandom);
    rst_n = 0;
    tick();
    clear_inputs();
    model_reset();
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.op_err", op_err, 0);
    check_outputs("rst");
    rst_n = 1;
    tick();

    run_op("add_bypass", 1, 1, 1, 'h7F, 'h01, 0);
    chk("add.res_const", alu_result, 'h80);
    chk("add.nv_const", {flag_n, flag_z, flag_c, flag_v}, 4'b1001);
    run_op("cmp_eq", 9, 1, 1, 'h05, 'h05, 0);
    chk("cmp.eq_const", cc_equal, 1);
    chk("cmp.res_hold", alu_result, 'h80);
    run_op("add_after_cmp", 1, 0, 0, 0, 0, 0);
    chk("add.eq_clr", cc_equal, 0);
    run_op("mul_ff", 10, 1, 1, 'hFF, 'hFF, 1);
    chk("mul.hi_const", alu_result_hi, 'hFE);
    chk("mul.lo_const", alu_result, 'h01);
    run_op("asr9", 8, 1, 1, 'h80, 9, 0);
    chk("asr.res_const", alu_result, 'hFF);
    run_op("lsl1", 6, 1, 1, 'h81, 1, 0);
    chk("lsl.c_const", flag_c, 1);
    run_op("ror9", 12, 1, 1, 'h01, 9, 0);
    chk("ror.res_const", alu_result, 'h80);
    run_op("illegal14", 14, 1, 1, 'h12, 'h34, 1);
    run_op("or_stored", 3, 0, 0, 0, 0, 0);

    // Abort a multiply partway through with reset.
    A_bus = 8'hC3; B_bus = 8'h5A; a_load = 1; b_load = 1; alu_op = 4'd10; start = 1;
    tick();
    clear_inputs();
    tick(); tick(); tick();
    rst_n = 0;
    tick();
    model_reset();
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    check_outputs("midrst");
    rst_n = 1;
    saw_done = 0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      if (done) saw_done = 1;
    end
    chk("midrst.no_done", saw_done, 0);
    run_op("or_after_rst", 3, 0, 0, 0, 0, 0);

    for (int i = 0; i < 90; i++) begin
      op = $urandom_range(0, 15);
      bv = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : $urandom_range(0, 255);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, 1'($urandom), 1'($urandom),
             $urandom_range(0, 255), bv, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
